// File: rtl/dbus_arbiter_pkg.sv
// Shared definitions for the data-bus arbiter.
//  - Port index constants used for grant, owner and read-tag routing.
//  - Read tag carried through the latency pipe: {valid, port}.
package dbus_arbiter_pkg;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    typedef struct packed {
        logic vld;
        logic port;
    } rtag_t;

    localparam int RTAG_W = $bits(rtag_t);

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of requester, memory and debug signals around dbus_arbiter.
//  m0_* : CPU core data bus       (req/we/addr/wdata in, gnt/rvalid/rdata out)
//  m1_* : UART debug path         (same set plus m1_lock)
//  s_*  : single data-memory port (read/write strobes out, s_r_data in)
//  owner: port granted most recently
// Modport slave is the arbiter's view; master is the environment
// (requesters plus memory) driving it.
interface dbus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          s_r_en;
    logic [AW-1:0] s_r_addr;
    logic [DW-1:0] s_r_data;
    logic          s_w_en;
    logic [AW-1:0] s_w_addr;
    logic [DW-1:0] s_w_data;

    logic          owner;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_gnt, m1_rvalid, m1_rdata,
        output s_r_en, s_r_addr, input s_r_data,
        output s_w_en, s_w_addr, s_w_data,
        output owner
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  s_r_en, s_r_addr, output s_r_data,
        input  s_w_en, s_w_addr, s_w_data,
        input  owner
    );

endinterface

// File: rtl/dbus_rtag_pipe.sv
// Read-tag latency pipe: DEPTH-deep shift register of {valid, port}.
// A tag enters on the read-grant cycle and leaves DEPTH clocks later,
// aligned with the memory's read data.
//  clk, rst : clock, asynchronous active-high reset (flushes in-flight tags)
//  i_tag    : tag for the read granted this cycle (vld=0 otherwise)
//  o_tag    : tag whose read data is on s_r_data this cycle
module dbus_rtag_pipe
    import dbus_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  rtag_t i_tag,
    output rtag_t o_tag
);

    rtag_t r_pipe [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dbus_arbiter.sv
// Data-memory port arbiter between the CPU (port 0) and the UART debug
// path (port 1). Round-robin, one access per cycle, with a bounded lock
// that lets port 1 keep the bus for multi-beat debug bursts.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : dbus_arbiter_if.slave (requesters, memory port, owner)
// Grants are combinational on the req lines; memory strobes follow the
// grant in the same cycle. Read data returns RD_LAT (1..4) cycles after
// the grant to the port that issued the read.
module dbus_arbiter
    import dbus_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst,
    dbus_arbiter_if.slave bus
);

    localparam int LCW = $clog2(MAX_LOCK + 1);

    logic           r_last;
    logic [LCW-1:0] r_lock_cnt;
    logic [AW-1:0]  r_r_addr;
    logic [AW-1:0]  r_w_addr;
    logic [DW-1:0]  r_w_data;
    logic [DW-1:0]  r_rdata0;
    logic [DW-1:0]  r_rdata1;

    logic           w_lock_hold;
    logic           w_gnt0;
    logic           w_gnt1;
    logic           w_any;
    logic           w_we;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_wdata;
    logic           w_rd;
    logic           w_wr;
    logic           w_rv0;
    logic           w_rv1;
    rtag_t          w_tag_in;
    rtag_t          w_tag_out;

    // Port 1 keeps the bus only while it was the last owner, still locks,
    // and has not used up its burst allowance.
    assign w_lock_hold = (r_last == PORT_DBG) && bus.m1_lock &&
                         (r_lock_cnt < LCW'(MAX_LOCK));

    // No grant while reset is asserted so outputs drop immediately.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (bus.m0_req && bus.m1_req) begin
                if (w_lock_hold || r_last == PORT_CPU) w_gnt1 = 1'b1;
                else                                   w_gnt0 = 1'b1;
            end else if (bus.m0_req) begin
                w_gnt0 = 1'b1;
            end else if (bus.m1_req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_we    = w_gnt1 ? bus.m1_we    : bus.m0_we;
    assign w_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
    assign w_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
    assign w_rd    = w_any & ~w_we;
    assign w_wr    = w_any &  w_we;

    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;
    assign bus.owner  = r_last;

    // Address/data pass through on a grant and otherwise show the last
    // value issued, so the memory port never sees idle-cycle garbage.
    assign bus.s_r_en   = w_rd;
    assign bus.s_r_addr = w_rd ? w_addr  : r_r_addr;
    assign bus.s_w_en   = w_wr;
    assign bus.s_w_addr = w_wr ? w_addr  : r_w_addr;
    assign bus.s_w_data = w_wr ? w_wdata : r_w_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last     <= PORT_DBG;
            r_lock_cnt <= '0;
            r_r_addr   <= '0;
            r_w_addr   <= '0;
            r_w_data   <= '0;
        end else begin
            if (w_any) r_last <= w_gnt1;
            if (w_rd)  r_r_addr <= w_addr;
            if (w_wr) begin
                r_w_addr <= w_addr;
                r_w_data <= w_wdata;
            end
            // Counts locked port-1 grants; saturates so the hand-over
            // condition stays true until port 0 is actually served.
            if (w_gnt0 || !bus.m1_lock)
                r_lock_cnt <= '0;
            else if (w_gnt1 && r_lock_cnt < LCW'(MAX_LOCK))
                r_lock_cnt <= r_lock_cnt + LCW'(1);
        end
    end

    assign w_tag_in.vld  = w_rd;
    assign w_tag_in.port = w_gnt1;

    dbus_rtag_pipe #(.DEPTH(RD_LAT)) u_rtag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_rv0 = w_tag_out.vld && (w_tag_out.port == PORT_CPU);
    assign w_rv1 = w_tag_out.vld && (w_tag_out.port == PORT_DBG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rv0) r_rdata0 <= bus.s_r_data;
            if (w_rv1) r_rdata1 <= bus.s_r_data;
        end
    end

    assign bus.m0_rvalid = w_rv0;
    assign bus.m1_rvalid = w_rv1;
    assign bus.m0_rdata  = w_rv0 ? bus.s_r_data : r_rdata0;
    assign bus.m1_rdata  = w_rv1 ? bus.s_r_data : r_rdata1;

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dbus_arbiter_if #(.AW(32), .DW(32)) ifa ();
    dbus_arbiter_if #(.AW(32), .DW(32)) ifb ();

    dbus_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_LOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    dbus_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .MAX_LOCK(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    // Memory model for dut: word array indexed by addr[9:2], 1-cycle read.
    logic [31:0] mem [0:255];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (ifa.s_w_en) mem[ifa.s_w_addr[9:2]] <= ifa.s_w_data;
        if (ifa.s_r_en) ifa.s_r_data <= mem[ifa.s_r_addr[9:2]];
    end

    assign ifb.s_r_data = 32'h0BAD_F00D;

    task automatic mem_load(input logic [7:0] idx, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic idle_a();
        ifa.m0_req = 1'b0; ifa.m0_we = 1'b0; ifa.m0_addr = '0; ifa.m0_wdata = '0;
        ifa.m1_req = 1'b0; ifa.m1_we = 1'b0; ifa.m1_addr = '0; ifa.m1_wdata = '0;
        ifa.m1_lock = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] v;
        @(negedge clk); #1;
        v = {ifa.m0_gnt, ifa.m1_gnt, ifa.s_r_en, ifa.s_w_en, ifa.m0_rvalid, ifa.m1_rvalid, ifa.owner};
        n_cmp++; if (v !== 7'b0000001) begin n_err++; $display("FAIL reset_ctl got=%b exp=0000001", v); end
        n_cmp++; if ({ifa.s_r_addr, ifa.s_w_addr, ifa.m0_rdata} !== 96'h0) begin
            n_err++; $display("FAIL reset_data got=%h exp=0", {ifa.s_r_addr, ifa.s_w_addr, ifa.m0_rdata}); end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            v = {ifa.m0_gnt, ifa.m1_gnt, ifa.s_r_en, ifa.s_w_en, ifa.m0_rvalid, ifa.m1_rvalid, ifa.owner};
            n_cmp++; if (v !== 7'b0000001) begin n_err++; $display("FAIL idle_%0d got=%b exp=0000001", i, v); end
        end
    endtask

    task automatic test_single_read();
        @(negedge clk);
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_addr = 32'h1004;
        #1;
        n_cmp++; if ({ifa.m0_gnt, ifa.m1_gnt} !== 2'b10) begin n_err++; $display("FAIL rd_gnt got=%b exp=10", {ifa.m0_gnt, ifa.m1_gnt}); end
        n_cmp++; if ({ifa.s_r_en, ifa.s_w_en} !== 2'b10) begin n_err++; $display("FAIL rd_strobe got=%b exp=10", {ifa.s_r_en, ifa.s_w_en}); end
        n_cmp++; if (ifa.s_r_addr !== 32'h1004) begin n_err++; $display("FAIL rd_addr got=%h exp=1004", ifa.s_r_addr); end
        @(negedge clk);
        ifa.m0_req = 1'b0;
        #1;
        n_cmp++; if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b10) begin n_err++; $display("FAIL rd_rvalid got=%b exp=10", {ifa.m0_rvalid, ifa.m1_rvalid}); end
        n_cmp++; if (ifa.m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef", ifa.m0_rdata); end
        n_cmp++; if (ifa.owner !== 1'b0) begin n_err++; $display("FAIL rd_owner got=%b exp=0", ifa.owner); end
        @(negedge clk); #1;
        n_cmp++; if (ifa.m0_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_pulse got=%b exp=0", ifa.m0_rvalid); end
        n_cmp++; if (ifa.m0_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold got=%h exp=deadbeef", ifa.m0_rdata); end
        n_cmp++; if (ifa.s_r_addr !== 32'h1004) begin n_err++; $display("FAIL rd_addr_hold got=%h exp=1004", ifa.s_r_addr); end
    endtask

    // Reset first so last=1 and port 0 wins the opening tie.
    task automatic test_round_robin();
        int c0 = 0, c1 = 0;
        logic ep, rv0, rv1;
        do_reset();
        ifa.m0_addr = 32'h1020; ifa.m1_addr = 32'h1030;
        ifa.m0_we = 1'b0; ifa.m1_we = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            ifa.m0_req = (k < 6); ifa.m1_req = (k < 6);
            #1;
            if (k < 6) begin
                ep = k[0];
                n_cmp++; if ({ifa.m0_gnt, ifa.m1_gnt} !== {~ep, ep}) begin
                    n_err++; $display("FAIL rr_gnt_%0d got=%b exp=%b", k, {ifa.m0_gnt, ifa.m1_gnt}, {~ep, ep}); end
                n_cmp++; if (ifa.s_r_addr !== (ep ? 32'h1030 : 32'h1020)) begin
                    n_err++; $display("FAIL rr_addr_%0d got=%h", k, ifa.s_r_addr); end
            end
            rv0 = (k > 0) && ((k - 1) % 2 == 0);
            rv1 = (k > 0) && ((k - 1) % 2 == 1);
            n_cmp++; if ({ifa.m0_rvalid, ifa.m1_rvalid} !== {rv0, rv1}) begin
                n_err++; $display("FAIL rr_rv_%0d got=%b exp=%b", k, {ifa.m0_rvalid, ifa.m1_rvalid}, {rv0, rv1}); end
            if (ifa.m0_rvalid === 1'b1) begin
                c0++;
                n_cmp++; if (ifa.m0_rdata !== 32'hA0A0_0000) begin n_err++; $display("FAIL rr_d0_%0d got=%h exp=a0a00000", k, ifa.m0_rdata); end
            end
            if (ifa.m1_rvalid === 1'b1) begin
                c1++;
                n_cmp++; if (ifa.m1_rdata !== 32'hB1B1_0001) begin n_err++; $display("FAIL rr_d1_%0d got=%h exp=b1b10001", k, ifa.m1_rdata); end
            end
        end
        n_cmp++; if (c0 !== 3) begin n_err++; $display("FAIL rr_cnt0 got=%0d exp=3", c0); end
        n_cmp++; if (c1 !== 3) begin n_err++; $display("FAIL rr_cnt1 got=%0d exp=3", c1); end
    endtask

    task automatic test_lock();
        int exp4 [6] = '{1, 1, 1, 1, 0, 1};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            ifa.m0_req = 1'b1; ifa.m1_req = 1'b1; ifa.m1_lock = 1'b1;
            #1;
            n_cmp++; if (ifa.m1_gnt !== 1'(exp4[k]) || ifa.m0_gnt !== 1'(1 - exp4[k])) begin
                n_err++; $display("FAIL lock_gnt_%0d got=%b%b exp_port=%0d", k, ifa.m0_gnt, ifa.m1_gnt, exp4[k]); end
        end
        @(negedge clk);
        idle_a();
        #1;
        n_cmp++; if (ifa.owner !== 1'b1) begin n_err++; $display("FAIL lock_owner got=%b exp=1", ifa.owner); end
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        @(negedge clk);
        ifa.m1_req = 1'b1; ifa.m1_we = 1'b1; ifa.m1_addr = 32'h1010; ifa.m1_wdata = 32'h55;
        #1;
        n_cmp++; if ({ifa.m1_gnt, ifa.s_w_en, ifa.s_r_en} !== 3'b110) begin
            n_err++; $display("FAIL wr_strobe got=%b exp=110", {ifa.m1_gnt, ifa.s_w_en, ifa.s_r_en}); end
        n_cmp++; if ({ifa.s_w_addr, ifa.s_w_data} !== {32'h1010, 32'h55}) begin
            n_err++; $display("FAIL wr_addr_data got=%h/%h exp=1010/55", ifa.s_w_addr, ifa.s_w_data); end
        @(negedge clk);
        ifa.m1_req = 1'b0; ifa.m1_we = 1'b0;
        ifa.m0_req = 1'b1; ifa.m0_we = 1'b0; ifa.m0_addr = 32'h1010;
        #1;
        n_cmp++; if ({ifa.m0_gnt, ifa.s_r_en, ifa.s_w_en} !== 3'b110) begin
            n_err++; $display("FAIL wr_rd_strobe got=%b exp=110", {ifa.m0_gnt, ifa.s_r_en, ifa.s_w_en}); end
        n_cmp++; if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b00) begin
            n_err++; $display("FAIL wr_no_rvalid got=%b exp=00", {ifa.m0_rvalid, ifa.m1_rvalid}); end
        @(negedge clk);
        ifa.m0_req = 1'b0;
        #1;
        n_cmp++; if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b10) begin
            n_err++; $display("FAIL wr_rd_rvalid got=%b exp=10", {ifa.m0_rvalid, ifa.m1_rvalid}); end
        n_cmp++; if (ifa.m0_rdata !== 32'h55) begin n_err++; $display("FAIL wr_rd_data got=%h exp=55", ifa.m0_rdata); end
        n_cmp++; if (ifa.s_w_addr !== 32'h1010) begin n_err++; $display("FAIL wr_addr_hold got=%h exp=1010", ifa.s_w_addr); end
    endtask

    // Second instance with RD_LAT=2: reset lands while the read is in flight.
    task automatic test_reset_mid_read();
        @(negedge clk);
        ifb.m0_req = 1'b1; ifb.m0_we = 1'b0; ifb.m0_addr = 32'h2000;
        #1;
        n_cmp++; if ({ifb.m0_gnt, ifb.s_r_en} !== 2'b11) begin n_err++; $display("FAIL mr_gnt got=%b exp=11", {ifb.m0_gnt, ifb.s_r_en}); end
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        n_cmp++; if ({ifb.m0_gnt, ifb.s_r_en, ifb.m0_rvalid, ifb.m1_rvalid} !== 4'b0000) begin
            n_err++; $display("FAIL mr_async got=%b exp=0000", {ifb.m0_gnt, ifb.s_r_en, ifb.m0_rvalid, ifb.m1_rvalid}); end
        n_cmp++; if (ifb.s_r_addr !== 32'h0) begin n_err++; $display("FAIL mr_addr got=%h exp=0", ifb.s_r_addr); end
        @(negedge clk);
        rst_b = 1'b0; ifb.m0_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({ifb.m0_rvalid, ifb.m1_rvalid} !== 2'b00) begin
                n_err++; $display("FAIL mr_rv_%0d got=%b exp=00", i, {ifb.m0_rvalid, ifb.m1_rvalid}); end
            @(negedge clk);
        end
    endtask

    initial begin
        idle_a();
        ifb.m0_req = 1'b0; ifb.m0_we = 1'b0; ifb.m0_addr = '0; ifb.m0_wdata = '0;
        ifb.m1_req = 1'b0; ifb.m1_we = 1'b0; ifb.m1_addr = '0; ifb.m1_wdata = '0;
        ifb.m1_lock = 1'b0;
        @(negedge clk);
        rst_b = 1'b0;
        test_reset();
        mem_load(8'd1,  32'hDEADBEEF);
        mem_load(8'd8,  32'hA0A0_0000);
        mem_load(8'd12, 32'hB1B1_0001);
        test_single_read();
        test_round_robin();
        test_lock();
        test_write_then_read();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
